line_clear_engine: RTL



---
 rtl/tetris_pkg.sv | 50 +++++
 rtl/row_full_detect.sv | 23 ++
 rtl/line_clear_engine.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: board geometry, cell encoding, line-clear FSM states and the score table
// shared by the board datapath blocks.
package tetris_pkg;

   localparam int ROWS    = 20;
   localparam int COLS    = 10;
   localparam int COLOR_W = 24;
   localparam int ROW_W   = 5;

   localparam logic [COLOR_W-1:0] EMPTY_CELL = '0;

   // Row pointers carry one extra sign bit so stepping below row 0 shows up as negative.
   typedef logic signed [ROW_W:0] rowPtr_t;

   localparam rowPtr_t PTR_ONE = rowPtr_t'(1);
   localparam rowPtr_t PTR_TOP = rowPtr_t'(ROWS - 1);

   typedef enum logic [2:0] {
      LC_IDLE,
      LC_RD_ADDR,
      LC_RD_WAIT,
      LC_EVAL,
      LC_WR,
      LC_CLR,
      LC_DONE
   } lcState_t;

   localparam logic [10:0] SCORE_0 = 11'd0;
   localparam logic [10:0] SCORE_1 = 11'd40;
   localparam logic [10:0] SCORE_2 = 11'd100;
   localparam logic [10:0] SCORE_3 = 11'd300;
   localparam logic [10:0] SCORE_4 = 11'd1200;

   // Once the read pointer has passed row 0, any rows left above the write pointer are zero-filled.
   function automatic lcState_t exitState(input rowPtr_t rd, input rowPtr_t wr);
      if (!rd[ROW_W]) return LC_RD_ADDR;
      return wr[ROW_W] ? LC_DONE : LC_CLR;
   endfunction

   function automatic logic [10:0] scoreFor(input logic [2:0] cnt);
      case (cnt)
         3'd0:    return SCORE_0;
         3'd1:    return SCORE_1;
         3'd2:    return SCORE_2;
         3'd3:    return SCORE_3;
         default: return SCORE_4;
      endcase
   endfunction

endpackage

// File: rtl/row_full_detect.sv
// row_full_detect: combinational check that every cell of a packed row holds a non-empty colour.
module row_full_detect
   import tetris_pkg::*;
#(
   parameter int NUM_COLS = COLS,
   parameter int CELL_W   = COLOR_W
) (
   input  logic [NUM_COLS*CELL_W-1:0] i_row,
   output logic                       o_full
);

   logic [NUM_COLS-1:0] w_cellFilled;

   always_comb begin
      w_cellFilled = '0;
      for (int c = 0; c < NUM_COLS; c++) begin
         w_cellFilled[c] = |i_row[c*CELL_W +: CELL_W];
      end
   end

   assign o_full = &w_cellFilled;

endmodule

// File: rtl/line_clear_engine.sv
// line_clear_engine: scans the board bottom-up, drops full rows, compacts survivors and zero-fills the top.
// Optional score output is enabled with the LINE_CLEAR_SCORE_EN macro.
module line_clear_engine
   import tetris_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [COLS*COLOR_W-1:0]  rd_data,
   output logic [ROW_W-1:0]         row_addr,
   output logic [COLS*COLOR_W-1:0]  wr_data,
   output logic [COLS-1:0]          we,
   output logic                     busy,
   output logic                     done,
   output logic [2:0]               lines_cleared
`ifdef LINE_CLEAR_SCORE_EN
   ,
   output logic [10:0]              score_add
`endif
);

   lcState_t r_state;
   rowPtr_t  r_rd;
   rowPtr_t  r_wr;
   logic [2:0] r_cnt;

   logic     w_rowFull;
   rowPtr_t  w_evalRd;
   rowPtr_t  w_evalWr;
   logic [2:0] w_evalCnt;
   logic     w_evalWrite;
   lcState_t w_evalNext;
   rowPtr_t  w_wrRd;
   rowPtr_t  w_wrWr;
   lcState_t w_wrNext;

   row_full_detect #(
      .NUM_COLS (COLS),
      .CELL_W   (COLOR_W)
   ) u_rowFull (
      .i_row  (rd_data),
      .o_full (w_rowFull)
   );

   // Pointer updates for the row being evaluated; a surviving row that is already in place needs no write.
   always_comb begin
      w_evalRd    = r_rd;
      w_evalWr    = r_wr;
      w_evalCnt   = r_cnt;
      w_evalWrite = 1'b0;
      if (w_rowFull) begin
         w_evalRd  = r_rd - PTR_ONE;
         w_evalCnt = (r_cnt == 3'd7) ? r_cnt : r_cnt + 3'd1;
      end else if (r_wr == r_rd) begin
         w_evalRd = r_rd - PTR_ONE;
         w_evalWr = r_wr - PTR_ONE;
      end else begin
         w_evalWrite = 1'b1;
      end
      w_evalNext = exitState(w_evalRd, w_evalWr);
   end

   always_comb begin
      w_wrRd   = r_rd - PTR_ONE;
      w_wrWr   = r_wr - PTR_ONE;
      w_wrNext = exitState(w_wrRd, w_wrWr);
   end

   // All outputs are registered, so write cycles are set up on the edge that enters WR or CLR.
   // wr_data doubles as the row buffer holding the last evaluated row.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= LC_IDLE;
         r_rd          <= '0;
         r_wr          <= '0;
         r_cnt         <= '0;
         row_addr      <= '0;
         wr_data       <= '0;
         we            <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         lines_cleared <= '0;
`ifdef LINE_CLEAR_SCORE_EN
         score_add     <= '0;
`endif
      end else begin
         we   <= '0;
         done <= 1'b0;
         case (r_state)
            LC_IDLE: begin
               if (start) begin
                  r_rd    <= PTR_TOP;
                  r_wr    <= PTR_TOP;
                  r_cnt   <= '0;
                  busy    <= 1'b1;
                  r_state <= LC_RD_ADDR;
               end
            end
            LC_RD_ADDR: begin
               row_addr <= r_rd[ROW_W-1:0];
               r_state  <= LC_RD_WAIT;
            end
            LC_RD_WAIT: begin
               r_state <= LC_EVAL;
            end
            LC_EVAL: begin
               wr_data <= rd_data;
               if (w_evalWrite) begin
                  row_addr <= r_wr[ROW_W-1:0];
                  we       <= '1;
                  r_state  <= LC_WR;
               end else begin
                  r_rd    <= w_evalRd;
                  r_wr    <= w_evalWr;
                  r_cnt   <= w_evalCnt;
                  r_state <= w_evalNext;
                  if (w_evalNext == LC_CLR) begin
                     row_addr <= w_evalWr[ROW_W-1:0];
                     wr_data  <= {COLS{EMPTY_CELL}};
                     we       <= '1;
                  end
               end
            end
            LC_WR: begin
               r_rd    <= w_wrRd;
               r_wr    <= w_wrWr;
               r_state <= w_wrNext;
               if (w_wrNext == LC_CLR) begin
                  row_addr <= w_wrWr[ROW_W-1:0];
                  wr_data  <= {COLS{EMPTY_CELL}};
                  we       <= '1;
               end
            end
            LC_CLR: begin
               r_wr <= w_wrWr;
               if (r_wr == '0) begin
                  r_state <= LC_DONE;
               end else begin
                  row_addr <= w_wrWr[ROW_W-1:0];
                  we       <= '1;
               end
            end
            LC_DONE: begin
               done          <= 1'b1;
               busy          <= 1'b0;
               lines_cleared <= r_cnt;
`ifdef LINE_CLEAR_SCORE_EN
               score_add     <= scoreFor(r_cnt);
`endif
               r_state       <= LC_IDLE;
            end
            default: begin
               r_state <= LC_IDLE;
            end
         endcase
      end
   end

endmodule
